// File: rtl/univ_shift_rotate_seq.sv
// Multi-cycle universal shift/rotate register with a start/busy/done handshake.
// Optional abort input enabled by defining UNIV_SHIFT_ROTATE_ABORT_EN.
module univ_shift_rotate_seq #(
    parameter int          DW   = 8,
    parameter int          AW   = 3,
    parameter int unsigned STEP = 1
) (
    input  logic          clk,
    input  logic          async_rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW-1:0] amt,
    input  logic [DW-1:0] data,
    input  logic          ser_in,
`ifdef UNIV_SHIFT_ROTATE_ABORT_EN
    input  logic          abort,
`endif
    output logic [DW-1:0] q,
    output logic          busy,
    output logic          done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ROR  = 3'd1;
    localparam logic [2:0] OP_ROL  = 3'd2;
    localparam logic [2:0] OP_LSR  = 3'd3;
    localparam logic [2:0] OP_LSL  = 3'd4;
    localparam logic [2:0] OP_ASR  = 3'd5;

    state_t        state, state_n;
    logic [2:0]    op_r, op_n;
    logic [AW-1:0] remaining, rem_n;
    logic [DW-1:0] q_n, shifted;
    logic          busy_n, done_n, abort_w;
    int unsigned   rem_i, n;

`ifdef UNIV_SHIFT_ROTATE_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    function automatic logic [DW-1:0] step1(input logic [DW-1:0] v, input logic [2:0] o,
                                            input logic fill);
        case (o)
            OP_ROR:  step1 = {v[0], v[DW-1:1]};
            OP_ROL:  step1 = {v[DW-2:0], v[DW-1]};
            OP_LSR:  step1 = {fill, v[DW-1:1]};
            OP_LSL:  step1 = {v[DW-2:0], fill};
            OP_ASR:  step1 = {v[DW-1], v[DW-1:1]};
            default: step1 = v;
        endcase
    endfunction

    // A step of n positions is n chained single-bit moves; ASR re-reads the
    // preserved MSB each time, so the fill stays the original sign bit.
    always_comb begin
        rem_i   = 32'(remaining);
        n       = (rem_i > STEP) ? STEP : rem_i;
        shifted = q;
        for (int unsigned k = 0; k < STEP; k++)
            if (k < n) shifted = step1(shifted, op_r, ser_in);
    end

    always_comb begin
        state_n = state;
        q_n     = q;
        busy_n  = busy;
        done_n  = 1'b0;
        rem_n   = remaining;
        op_n    = op_r;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_LOAD: begin
                            q_n    = data;
                            done_n = 1'b1;
                        end
                        OP_ROR, OP_ROL, OP_LSR, OP_LSL, OP_ASR: begin
                            if (amt == '0) begin
                                done_n = 1'b1;
                            end else begin
                                op_n    = op;
                                rem_n   = amt;
                                busy_n  = 1'b1;
                                state_n = RUN;
                            end
                        end
                        default: done_n = 1'b1;
                    endcase
                end
            end
            RUN: begin
                if (abort_w) begin
                    busy_n  = 1'b0;
                    rem_n   = '0;
                    state_n = IDLE;
                end else begin
                    q_n   = shifted;
                    rem_n = remaining - AW'(n);
                    if (rem_n == '0) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state     <= IDLE;
            q         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            op_r      <= '0;
        end else begin
            state     <= state_n;
            q         <= q_n;
            busy      <= busy_n;
            done      <= done_n;
            remaining <= rem_n;
            op_r      <= op_n;
        end
    end

endmodule

// File: tb/tb_univ_shift_rotate_seq.sv
// Bench for univ_shift_rotate_seq: STEP=1 and STEP=2 instances driven in lockstep,
// every cycle compared against an amount-based reference model.
module tb_univ_shift_rotate_seq;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          async_rst;
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [DW-1:0] data;
    logic          ser_in;
    logic [DW-1:0] q1, q2;
    logic          busy1, busy2, done1, done2;

    int nvec = 0;
    int nerr = 0;
    logic [DW-1:0] mq [2];

    always #5 clk = ~clk;

    univ_shift_rotate_seq #(.DW(DW), .AW(AW), .STEP(1)) u_s1 (
        .clk(clk), .async_rst(async_rst), .start(start), .op(op), .amt(amt),
        .data(data), .ser_in(ser_in),
`ifdef UNIV_SHIFT_ROTATE_ABORT_EN
        .abort(1'b0),
`endif
        .q(q1), .busy(busy1), .done(done1));

    univ_shift_rotate_seq #(.DW(DW), .AW(AW), .STEP(2)) u_s2 (
        .clk(clk), .async_rst(async_rst), .start(start), .op(op), .amt(amt),
        .data(data), .ser_in(ser_in),
`ifdef UNIV_SHIFT_ROTATE_ABORT_EN
        .abort(1'b0),
`endif
        .q(q2), .busy(busy2), .done(done2));

    // Value after moving k positions from q0, computed directly from the op's meaning.
    function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] q0, input logic [2:0] o,
                                            input int k, input logic f, input logic [DW-1:0] d);
        logic [2*DW-1:0]      dd, t;
        logic [DW-1:0]        ones, m;
        logic signed [DW-1:0] s;
        dd   = {q0, q0};
        ones = '1;
        s    = q0;
        case (o)
            3'd0: ref_q = d;
            3'd1: begin t = dd >> (k % DW); ref_q = t[DW-1:0]; end
            3'd2: begin t = dd << (k % DW); ref_q = t[2*DW-1:DW]; end
            3'd3: begin
                m = ~(ones >> k);
                ref_q = (k >= DW) ? {DW{f}} : ((q0 >> k) | (f ? m : '0));
            end
            3'd4: begin
                m = ~(ones << k);
                ref_q = (k >= DW) ? {DW{f}} : ((q0 << k) | (f ? m : '0));
            end
            3'd5: ref_q = (k >= DW) ? {DW{q0[DW-1]}} : DW'(s >>> k);
            default: ref_q = q0;
        endcase
    endfunction

    // Issue one command from a negedge and check both instances every cycle.
    // Returns at a negedge so the next command may be issued back-to-back.
    task automatic cmd(input logic [2:0] o, input int k, input logic [DW-1:0] d,
                       input logic f, input bit inject, input int extra);
        logic [DW-1:0] q0 [2];
        logic [DW-1:0] eq;
        logic          eb, ed;
        logic [DW-1:0] aq;
        logic          ab, ad;
        bit            mv;
        int            L, S, j, mvd;
        q0[0] = mq[0];
        q0[1] = mq[1];
        mv = (o >= 3'd1 && o <= 3'd5 && k > 0);
        start = 1'b1; op = o; amt = AW'(k); data = d; ser_in = f;
        for (int m = 1; m <= (mv ? k : 0) + 1 + extra; m++) begin
            @(negedge clk);
            if (m == 1) start = 1'b0;
            for (int s = 0; s < 2; s++) begin
                S = s + 1;
                aq = (s == 0) ? q1 : q2;
                ab = (s == 0) ? busy1 : busy2;
                ad = (s == 0) ? done1 : done2;
                if (!mv) begin
                    eq = ref_q(q0[s], o, k, f, d);
                    eb = 1'b0;
                    ed = (m == 1);
                end else begin
                    L   = (k + S - 1) / S;
                    j   = m - 1;
                    mvd = (j * S < k) ? j * S : k;
                    eq  = ref_q(q0[s], o, mvd, f, d);
                    eb  = (j < L);
                    ed  = (j == L);
                end
                nvec += 3;
                if (aq !== eq) begin
                    nerr++;
                    $display("FAIL q step%0d op%0d amt%0d cyc%0d: got %h want %h", S, o, k, m, aq, eq);
                end
                if (ab !== eb) begin
                    nerr++;
                    $display("FAIL busy step%0d op%0d amt%0d cyc%0d: got %b want %b", S, o, k, m, ab, eb);
                end
                if (ad !== ed) begin
                    nerr++;
                    $display("FAIL done step%0d op%0d amt%0d cyc%0d: got %b want %b", S, o, k, m, ad, ed);
                end
            end
            if (inject && m == 2) begin
                start = 1'b1; op = 3'd0; data = 8'hFF;
            end
            if (inject && m == 3) start = 1'b0;
        end
        mq[0] = ref_q(q0[0], o, k, f, d);
        mq[1] = ref_q(q0[1], o, k, f, d);
    endtask

    task automatic chk_final(input string name, input logic [DW-1:0] want);
        nvec += 2;
        if (q1 !== want) begin
            nerr++;
            $display("FAIL %s step1: got %h want %h", name, q1, want);
        end
        if (q2 !== want) begin
            nerr++;
            $display("FAIL %s step2: got %h want %h", name, q2, want);
        end
    endtask

    task automatic chk_zero(input string name);
        nvec++;
        if ({q1, busy1, done1, q2, busy2, done2} !== '0) begin
            nerr++;
            $display("FAIL %s: got q1=%h b1=%b d1=%b q2=%h b2=%b d2=%b want all 0",
                     name, q1, busy1, done1, q2, busy2, done2);
        end
    endtask

    task automatic test_reset();
        async_rst = 1'b1; start = 1'b0; op = '0; amt = '0; data = '0; ser_in = 1'b0;
        #1 chk_zero("reset_async");
        repeat (2) @(negedge clk);
        chk_zero("reset_held");
        async_rst = 1'b0;
        @(negedge clk);
        chk_zero("reset_release_idle");
        mq[0] = '0;
        mq[1] = '0;
    endtask

    task automatic test_load_rol();
        cmd(3'd0, 0, 8'hA5, 1'b0, 0, 1);
        chk_final("load_a5", 8'hA5);
        cmd(3'd2, 3, 8'h00, 1'b0, 0, 1);
        chk_final("rol3", 8'h2D);
    endtask

    task automatic test_asr();
        cmd(3'd0, 0, 8'h96, 1'b0, 0, 0);
        cmd(3'd5, 2, 8'h00, 1'b0, 0, 1);
        chk_final("asr2", 8'hE5);
    endtask

    task automatic test_lsl_fill();
        cmd(3'd0, 0, 8'h3C, 1'b0, 0, 0);
        cmd(3'd4, 4, 8'h00, 1'b1, 0, 1);
        chk_final("lsl4_fill1", 8'hCF);
        cmd(3'd0, 0, 8'h3C, 1'b0, 0, 0);
        cmd(3'd4, 4, 8'h00, 1'b0, 0, 1);
        chk_final("lsl4_fill0", 8'hC0);
    endtask

    task automatic test_multistep_ror();
        cmd(3'd0, 0, 8'h01, 1'b0, 0, 0);
        cmd(3'd1, 5, 8'h00, 1'b0, 0, 1);
        chk_final("ror5", 8'h08);
    endtask

    task automatic test_ignore_zero();
        cmd(3'd0, 0, 8'h5C, 1'b0, 0, 0);
        cmd(3'd1, 6, 8'h00, 1'b0, 1, 1);
        chk_final("ror6_ignore", 8'h71);
        cmd(3'd2, 0, 8'h00, 1'b0, 0, 1);
        chk_final("rol0", 8'h71);
        cmd(3'd7, 5, 8'hFF, 1'b1, 0, 1);
        chk_final("hold", 8'h71);
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op = 3'd1; amt = 3'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 async_rst = 1'b1;
        #1 chk_zero("reset_mid_run");
        @(negedge clk);
        async_rst = 1'b0;
        mq[0] = '0;
        mq[1] = '0;
        @(negedge clk);
        chk_zero("reset_mid_after");
        cmd(3'd0, 0, 8'h5A, 1'b0, 0, 1);
        chk_final("load_5a_after_reset", 8'h5A);
    endtask

    task automatic test_back_to_back();
        cmd(3'd0, 0, 8'hC3, 1'b0, 0, 0);
        cmd(3'd3, 3, 8'h00, 1'b1, 0, 0);
        cmd(3'd2, 7, 8'h00, 1'b0, 0, 0);
        cmd(3'd6, 0, 8'h00, 1'b0, 0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++)
            cmd(3'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 8'($urandom),
                1'($urandom), 0, int'($urandom_range(0, 1)));
    endtask

    initial begin
        test_reset();
        test_load_rol();
        test_asr();
        test_lsl_fill();
        test_multistep_ror();
        test_ignore_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
